reg_cmd_initiator: RTL

Register-interface initiator that turns a valid/ready command stream into single register-bus transactions toward the peripheral reg slaves (SoC controller, fast interrupt controller, UART) and returns each result on a valid/ready response stream. It is the requesting end of the reg_req/reg_rsp protocol those peripherals answer. It lets a non-AXI agent (boot loader, debug bridge, test DMA) drive peripheral registers without going through the bus subsystem. It issues one outstanding transaction at a time, keeps a saturating error counter and, optionally, enforces a response timeout.

---
 rtl/reg_cmd_initiator.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_cmd_initiator.sv
// Register-bus initiator: one valid/ready command -> one reg_req transaction -> one response.
// Optional response timeout enabled by defining REG_CMD_INITIATOR_TIMEOUT_EN.
module reg_cmd_initiator #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_write_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_wstrb_i,
  output logic            reg_valid_o,
  output logic            reg_write_o,
  output logic [AW-1:0]   reg_addr_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic [DW/8-1:0] reg_wstrb_o,
  input  logic            reg_ready_i,
  input  logic [DW-1:0]   reg_rdata_i,
  input  logic            reg_error_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_error_o,
  output logic            rsp_timeout_o,
  output logic [15:0]     err_count_o
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_e          state_q, state_d;
  logic            accept_s, done_s, timeout_s, tmo_hit_s;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            error_q, error_d;
  logic [15:0]     err_count_q, err_count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A slave ready in the last allowed REQ cycle takes precedence over the timeout.
  always_comb begin
    state_d   = state_q;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept_s = 1'b1;
          state_d  = ST_REQ;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (reg_ready_i) begin
          done_s  = 1'b1;
          state_d = ST_RSP;
        end else if (tmo_hit_s) begin
          timeout_s = 1'b1;
          state_d   = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
      wstrb_q <= {SW{1'b0}};
    end else if (accept_s) begin
      write_q <= cmd_write_i;
      addr_q  <= cmd_addr_i;
      wdata_q <= cmd_wdata_i;
      wstrb_q <= cmd_wstrb_i;
    end
  end

  always_comb begin
    rdata_d     = rdata_q;
    error_d     = error_q;
    err_count_d = err_count_q;
    if (done_s) begin
      rdata_d = write_q ? {DW{1'b0}} : reg_rdata_i;
      error_d = reg_error_i;
    end else if (timeout_s) begin
      rdata_d = {DW{1'b0}};
      error_d = 1'b1;
    end else begin
      rdata_d = rdata_q;
      error_d = error_q;
    end
    if ((done_s && reg_error_i) || timeout_s) begin
      err_count_d = sat_inc16(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q     <= {DW{1'b0}};
      error_q     <= 1'b0;
      err_count_q <= 16'h0000;
    end else begin
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef REG_CMD_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;

  // tcnt_q holds the number of REQ cycles already completed without a slave ready.
  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    if (accept_s) begin
      tcnt_d = 16'h0000;
    end else if (state_q == ST_REQ) begin
      tcnt_d = tcnt_q + 16'd1;
    end else begin
      tcnt_d = tcnt_q;
    end
    if (done_s) begin
      timeout_d = 1'b0;
    end else if (timeout_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt_q    <= 16'h0000;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign tmo_hit_s     = (tcnt_q == TMO_LAST);
  assign rsp_timeout_o = timeout_q;
`else
  // TIMEOUT_CYCLES stays in the parameter list so both builds share one interface.
  logic unused_tmo_s;
  assign unused_tmo_s  = (TIMEOUT_CYCLES != 32'd0);
  assign tmo_hit_s     = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  assign cmd_ready_o = (state_q == ST_IDLE) & ~rst_i;
  assign reg_valid_o = (state_q == ST_REQ);
  assign reg_write_o = write_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;
  assign rsp_valid_o = (state_q == ST_RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign err_count_o = err_count_q;

endmodule
